// File: rtl/vec100_pkg.sv
// Shared definitions for the 100-bit test-vector pattern generator:
// sizes, the FSM state encoding, the LFSR default seed and helpers.
package vec100_pkg;

    localparam int VEC_W        = 100;
    localparam int IDX_W        = 7;
    localparam int CORNER_WORDS = 4;
    localparam int WALK_WORDS   = 100;
    localparam int LFSR_TAP     = 37;

    typedef logic [VEC_W-1:0] vec_t;

    // Used whenever a zero seed is supplied; an all-zero LFSR would lock up.
    localparam vec_t LFSR_DEFAULT_SEED = 100'hC0FFEE123456789ABCDEF1357;

    // Low-order 18-bit mask used by the third and fourth corner words.
    localparam vec_t CORNER_MASK = 100'h3ffff;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CORNER = 3'd1,
        ST_WALK1  = 3'd2,
        ST_WALK0  = 3'd3,
        ST_RAND   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Fibonacci x^100 + x^37 + 1: shift toward the MSB, feedback from
    // bit 99 (x^100) and bit 36 (x^37) into bit 0.
    function automatic vec_t lfsr_next(input vec_t s);
        return {s[VEC_W-2:0], s[VEC_W-1] ^ s[LFSR_TAP-1]};
    endfunction

    // Corner words in emission order: zeros, ones, low mask, inverted mask.
    function automatic vec_t corner_word(input logic [1:0] sel);
        vec_t w;
        case (sel)
            2'd0:    w = '0;
            2'd1:    w = '1;
            2'd2:    w = CORNER_MASK;
            default: w = ~CORNER_MASK;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/vec100_lfsr.sv
// 100-bit Fibonacci LFSR (x^100 + x^37 + 1) with synchronous load and step.
// A zero seed is replaced by LFSR_DEFAULT_SEED so the register never locks up.
module vec100_lfsr
    import vec100_pkg::*;
(
    input  logic clk,
    input  logic aresetn,
    input  logic load,
    input  vec_t seed,
    input  logic step,
    output vec_t state
);

    // LFSR register: load has priority over step.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/vec100_pattern_gen.sv
// 100-bit test-vector pattern generator. One start request produces
// 4 corner words, 100 walking-ones, 100 walking-zeros, then rand_count
// LFSR words, over a valid/ready stream with a registered data path.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// CORNER | emitting the 4 corner words
// WALK1  | emitting 100'h1 << index, index = 0..99
// WALK0  | emitting ~(100'h1 << index), index = 0..99
// RAND   | emitting LFSR state, one step per transferred word
// DONE   | single-cycle tail with busy still high, then IDLE
module vec100_pattern_gen
    import vec100_pkg::*;
#(
    parameter int RAND_MAX_W = 8
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [VEC_W-1:0]      seed,
    input  logic [RAND_MAX_W-1:0] rand_count,
    output logic                  pat_valid,
    input  logic                  pat_ready,
    output logic [VEC_W-1:0]      pat_data,
    output logic                  pat_last,
    output logic                  busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        index;
    logic [IDX_W-1:0]        idx_nxt;
    logic [RAND_MAX_W-1:0]   rand_left;
    vec_t                    word_nxt;
    vec_t                    lfsr_state;

    logic accept;
    logic fire;
    logic advance;
    logic corner_end;
    logic walk_end;
    logic rand_end;
    logic rand_skip;

    // Handshake and terminal-count qualifiers; all derived from registers
    // except fire, which only steers register loads, never pat_data directly.
    always_comb begin
        accept     = (state == ST_IDLE) && start;
        fire       = pat_valid && pat_ready;
        advance    = accept || fire;
        corner_end = (index == IDX_W'(CORNER_WORDS - 1));
        walk_end   = (index == IDX_W'(WALK_WORDS - 1));
        rand_end   = (rand_left == RAND_MAX_W'(1));
        rand_skip  = (rand_left == '0);
    end

    vec100_lfsr u_lfsr (
        .clk     (clk),
        .aresetn (aresetn),
        .load    (accept),
        .seed    (seed),
        .step    (fire && (state == ST_RAND)),
        .state   (lfsr_state)
    );

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: phases advance only when their final word transfers.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CORNER;
            ST_CORNER: if (fire && corner_end) state_nxt = ST_WALK1;
            ST_WALK1:  if (fire && walk_end) state_nxt = ST_WALK0;
            ST_WALK0:  if (fire && walk_end) state_nxt = rand_skip ? ST_DONE : ST_RAND;
            ST_RAND:   if (fire && rand_end) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the state register and counters.
    always_comb begin
        pat_valid = 1'b0;
        busy      = (state != ST_IDLE);
        pat_last  = 1'b0;
        case (state)
            ST_CORNER, ST_WALK1: pat_valid = 1'b1;
            ST_WALK0: begin
                pat_valid = 1'b1;
                pat_last  = walk_end && rand_skip;
            end
            ST_RAND: begin
                pat_valid = 1'b1;
                pat_last  = rand_end;
            end
            default: pat_valid = 1'b0;
        endcase
    end

    // Next word to present: index restarts on every phase change. Entering
    // RAND shows the freshly loaded seed; within RAND the word is the stepped
    // LFSR value, matching the step the LFSR takes on the same edge.
    always_comb begin
        idx_nxt = (state_nxt != state) ? '0 : index + IDX_W'(1);
        case (state_nxt)
            ST_CORNER: word_nxt = corner_word(idx_nxt[1:0]);
            ST_WALK1:  word_nxt = vec_t'(1) << idx_nxt;
            ST_WALK0:  word_nxt = ~(vec_t'(1) << idx_nxt);
            ST_RAND:   word_nxt = (state == ST_RAND) ? lfsr_next(lfsr_state) : lfsr_state;
            default:   word_nxt = '0;
        endcase
    end

    // Data path registers: index, remaining random words, presented word.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            index     <= '0;
            rand_left <= '0;
            pat_data  <= '0;
        end else begin
            if (accept) begin
                rand_left <= rand_count;
            end else if (fire && (state == ST_RAND)) begin
                rand_left <= rand_left - RAND_MAX_W'(1);
            end
            if (advance) begin
                index    <= idx_nxt;
                pat_data <= word_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vec100_pattern_gen.sv
// Directed bench for vec100_pattern_gen: full sequences with and without
// back-pressure, random-phase golden model, start while busy, mid-run reset.
module tb_vec100_pattern_gen;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        start;
    logic [99:0] seed;
    logic [7:0]  rand_count;
    logic        pat_valid;
    logic        pat_ready;
    logic [99:0] pat_data;
    logic        pat_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [99:0] DEF_SEED = 100'hC0FFEE123456789ABCDEF1357;

    always #5 clk = ~clk;

    vec100_pattern_gen #(.RAND_MAX_W(8)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .start      (start),
        .seed       (seed),
        .rand_count (rand_count),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .pat_data   (pat_data),
        .pat_last   (pat_last),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [99:0] golden_step(input logic [99:0] s);
        logic fb;
        fb = s[99] ^ s[36];
        return (s << 1) | {99'd0, fb};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, pat_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_last"},  pat_last,  1'b0);
        check({tag, "_data"},  pat_data,  100'h0);
    endtask

    // Called just after a falling edge with the DUT idle.
    task automatic run_seq(input logic [99:0] sd, input int rc, input bit rnd_ready,
                           input int pulse_at, input int abort_at);
        logic [99:0] rw[$];
        logic [99:0] s, expw, prev_data, one, cmask;
        logic        prev_last;
        bit          prev_stall;
        int          k, total, cyc;

        one   = 100'h1;
        cmask = 100'h3ffff;
        total = 204 + rc;
        s = (sd == '0) ? DEF_SEED : sd;
        for (int i = 0; i < rc; i++) begin
            rw.push_back(s);
            s = golden_step(s);
        end

        seed       = sd;
        rand_count = rc[7:0];
        start      = 1'b1;
        pat_ready  = 1'b0;
        @(negedge clk);
        start      = 1'b0;

        k = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (k < total) begin
            if (cyc > 3000) begin
                check("timeout_words", k, total);
                start = 1'b0;
                return;
            end
            if (k == abort_at) begin
                #1 aresetn = 1'b0;
                #1 check_reset_outputs("abort");
                pat_ready = 1'b0;
                start     = 1'b0;
                @(negedge clk);
                check_reset_outputs("abort_held");
                aresetn = 1'b1;
                return;
            end
            pat_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (k == pulse_at);

            if (k < 4) begin
                case (k)
                    0:       expw = '0;
                    1:       expw = '1;
                    2:       expw = cmask;
                    default: expw = ~cmask;
                endcase
            end else if (k < 104) begin
                expw = one << (k - 4);
            end else if (k < 204) begin
                expw = ~(one << (k - 104));
            end else begin
                expw = rw[k - 204];
            end

            check("valid", pat_valid, 1'b1);
            check("busy",  busy,      1'b1);
            check("data",  pat_data,  expw);
            check("last",  pat_last,  (k == total - 1));
            if (prev_stall) begin
                check("hold_data", pat_data, prev_data);
                check("hold_last", pat_last, prev_last);
            end
            prev_stall = pat_valid && !pat_ready;
            prev_data  = pat_data;
            prev_last  = pat_last;
            if (pat_valid && pat_ready) k++;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        pat_ready = 1'b0;
        check("done_busy",  busy,      1'b1);
        check("done_valid", pat_valid, 1'b0);
        @(negedge clk);
        check("idle_busy",  busy,      1'b0);
        check("idle_valid", pat_valid, 1'b0);
    endtask

    initial begin
        aresetn    = 1'b0;
        start      = 1'b0;
        pat_ready  = 1'b0;
        seed       = '0;
        rand_count = '0;
        #2 check_reset_outputs("por");
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_release");

        run_seq(100'h5, 0, 1'b0, -1, -1);
        run_seq(100'h5, 0, 1'b1, -1, -1);
        run_seq(100'h1, 3, 1'b1, 60, -1);
        run_seq(100'h1, 3, 1'b0, -1, -1);
        run_seq(100'h0, 2, 1'b0, -1, -1);
        run_seq(100'h7, 0, 1'b0, -1, 154);
        run_seq(100'h9, 1, 1'b1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec100_pattern_gen.md
VEC100_PATTERN_GEN -- requirements
Module: vec100_pattern_gen

Interface
REQ-001 Parameter RAND_MAX_W, default 8, width of the random-word count input.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port aresetn  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  one-cycle request to begin a pattern sequence; sampled in IDLE only.
REQ-005 Port seed  input  100  LFSR seed, captured on an accepted start.
REQ-006 Port rand_count  input  RAND_MAX_W  number of random words, captured on an accepted start.
REQ-007 Port pat_valid  output  1  pat_data holds a valid word.
REQ-008 Port pat_ready  input  1  downstream accepts the word when high together with pat_valid.
REQ-009 Port pat_data  output  100  current 100-bit test vector.
REQ-010 Port pat_last  output  1  marks the final word of the sequence; qualified by pat_valid.
REQ-011 Port busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, CORNER, WALK1, WALK0, RAND, DONE.
REQ-013 IDLE with start=1 -> CORNER next cycle; captures seed and rand_count; clears index.
REQ-014 CORNER emits 4 words in order: 100'h0, all-ones, 100'h3ffff, ~100'h3ffff.
REQ-015 WALK1 emits 100 words, word i = 100'h1 << i, for i = 0..99.
REQ-016 WALK0 emits 100 words, word i = ~(100'h1 << i), for i = 0..99.
REQ-017 RAND emits rand_count words of LFSR state; rand_count=0 skips RAND (WALK0 -> DONE).
REQ-018 LFSR: 100-bit Fibonacci, polynomial x^100+x^37+1, shifts once per accepted RAND word.
REQ-019 Seed of all zeros is replaced by the package constant LFSR_DEFAULT_SEED.
REQ-020 One shared 7-bit index counts words within a phase; it wraps to 0 on each phase transition.
REQ-021 A word transfers only on a cycle with pat_valid && pat_ready.
REQ-022 After a transfer, the next word is presented the following cycle, giving one word per cycle at full throughput.
REQ-023 pat_valid is high in CORNER, WALK1, WALK0 and RAND; low in IDLE and DONE.
REQ-024 While pat_valid=1 and pat_ready=0, pat_data and pat_last are held stable.
REQ-025 pat_valid does not drop until the word has transferred.
REQ-026 pat_last=1 only on the final word: last RAND word, or WALK0 word 99 when rand_count=0.
REQ-027 DONE lasts exactly one cycle, then -> IDLE; busy=1 in DONE.
REQ-028 start asserted while busy is ignored; it is not queued.
REQ-029 Total words per sequence = 204 + rand_count.
REQ-030 pat_data is registered; there is no combinational path from pat_ready to pat_data.

Reset
REQ-031 aresetn=0 immediately forces IDLE, index=0, pat_valid=0, pat_last=0, busy=0, pat_data=0, LFSR=LFSR_DEFAULT_SEED.
REQ-032 Reset mid-sequence aborts the sequence; no partial word transfers after reset.
REQ-033 Release of reset takes effect synchronously; the first start is accepted no earlier than the first rising edge after release.

Structure
REQ-034 Shared package vec100_pkg holds: state enum, VEC_W=100, CORNER_WORDS=4, WALK_WORDS=100, LFSR_TAP=37, LFSR_DEFAULT_SEED.
REQ-035 The LFSR is one sub-module, vec100_lfsr, with ports load, seed, step and state.
REQ-036 All other logic (FSM, index, output registers) lives in vec100_pattern_gen.

Verification
REQ-037 Scenario: pat_ready tied 1, rand_count=0, start -> 204 words: 0, ~0, 3ffff, ~3ffff, walk-1, walk-0; pat_last on word 204; busy falls 2 cycles later.
REQ-038 Scenario: pat_ready toggling pseudo-randomly -> identical word stream to REQ-037; pat_data and pat_last stable during every stall.
REQ-039 Scenario: seed=100'h1, rand_count=3 -> 207 words; RAND words match a golden x^100+x^37+1 model; pat_last on word 207 only.
REQ-040 Scenario: seed=0 -> the first RAND word equals LFSR_DEFAULT_SEED.
REQ-041 Scenario: start pulsed during WALK1 -> no effect on the stream; start one cycle after DONE -> new sequence begins with 100'h0.
REQ-042 Scenario: aresetn low during WALK0 word 50 -> outputs reach reset values without waiting for a clock edge; the next start restarts at CORNER word 0.
